// File: rtl/mips_pkg.sv
// mips_pkg: shared decode constants and types for the single-cycle MIPS core.
//   opcode_e  - primary opcode field values (instr[31:26])
//   funct_e   - R-type function field values (instr[5:0])
//   alu_op_e  - operation select driven from the ALU-control decode
//   ctrl_t    - bundle of main-control outputs for one instruction
//   sext16    - sign-extend a 16-bit immediate to 32 bits
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_J     = 6'd2,
        OP_BEQ   = 6'd4,
        OP_BNE   = 6'd5,
        OP_LW    = 6'd35,
        OP_SW    = 6'd43
    } opcode_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'd32,
        FN_SUB = 6'd34,
        FN_AND = 6'd36,
        FN_OR  = 6'd37,
        FN_SLT = 6'd42
    } funct_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    reg_we;       // write the register file this cycle
        logic    reg_dst_rd;   // destination is rd (R-type) rather than rt
        logic    alu_src_imm;  // ALU operand B is the sign-extended immediate
        logic    mem_to_reg;   // write-back data comes from data memory
        logic    mem_we;       // store word to data memory
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_single_cycle_units.sv
// Datapath building blocks for mips_single_cycle.
//
// mips_single_cycle_mem: byte-wide memory with a combinational little-endian
//   word read and a clocked word write. Addresses wrap modulo BYTES.
//   clk in 1, we in 1, addr in 32, wdata in 32, rdata out 32.
//   Contents are never reset so preloaded images survive rst.
//
// mips_single_cycle_regfile: 32x32 register file, two combinational read
//   ports, one clocked write port. $0 reads as zero and ignores writes.
//   clk in 1, we in 1, ra1/ra2/wa in 5, wd in 32, rd1/rd2 out 32.
//
// mips_single_cycle_alu: combinational ALU.
//   a/b in 32, op in alu_op_e, y out 32, zero out 1 (y == 0).
module mips_single_cycle_mem #(
    parameter int BYTES = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [7:0] mem_array [0:BYTES-1];

    // Byte lane ofs of the word at base; the 32-bit add wraps first, then
    // the modulo folds the address into the array.
    function automatic logic [IDX_W-1:0] byte_idx(input logic [31:0] base,
                                                  input logic [1:0]  ofs);
        logic [31:0] a;
        a = base + {30'd0, ofs};
        return IDX_W'(a % BYTES);
    endfunction

    assign rdata = {mem_array[byte_idx(addr, 2'd3)],
                    mem_array[byte_idx(addr, 2'd2)],
                    mem_array[byte_idx(addr, 2'd1)],
                    mem_array[byte_idx(addr, 2'd0)]};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                mem_array[byte_idx(addr, 2'(k))] <= wdata[8*k +: 8];
            end
        end
    end
endmodule

module mips_single_cycle_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] file_array [0:31];

    // No write-through bypass: a read of the register being written returns
    // the value held before the edge.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : file_array[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : file_array[ra2];

    always_ff @(posedge clk) begin
        if (we && (wa != 5'd0)) begin
            file_array[wa] <= wd;
        end
    end
endmodule

module mips_single_cycle_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] y,
    output logic        zero
);
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
            default: y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);
endmodule

// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle 32-bit MIPS subset core.
//   Fetch, decode, execute, memory access and write-back all complete in one
//   clock. Instruction memory, data memory and register file are internal
//   and are loaded from outside through hierarchical paths.
// Ports:
//   clk  in 1  sole clock, all state changes on the rising edge
//   rst  in 1  asynchronous active-high reset; clears only the pc
// Parameters:
//   IMEM_BYTES  instruction memory size in bytes
//   DMEM_BYTES  data memory size in bytes
// Build option:
//   MIPS_SLT_EN  when defined, R-type funct 42 (SLT) is executed; otherwise
//                it decodes as an unknown funct (no write, pc+4).
module mips_single_cycle
    import mips_pkg::*;
#(
    parameter int IMEM_BYTES = 1024,
    parameter int DMEM_BYTES = 1024
) (
    input  logic clk,
    input  logic rst
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] rs_val, rt_val, alu_b, alu_y, dmem_rdata, rfile_wd;
    logic        alu_zero;
    logic [31:0] pc_plus4, branch_target, jump_target;
    logic        reg_we_eff, mem_we_eff, take_branch;
    ctrl_t       ctrl;

    assign pc       = pc_q;
    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign imm      = instr[15:0];
    assign funct    = instr[5:0];
    assign imm_sext = sext16(imm);

    mips_single_cycle_mem #(.BYTES(IMEM_BYTES)) InstrMem (
        .clk   (clk),
        .we    (1'b0),      // read-only in operation; loaded externally
        .addr  (pc_q),
        .wdata (32'd0),
        .rdata (instr)
    );

    // Main control and ALU control in one decode.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst_rd = 1'b1;
                case (funct)
                    FN_ADD: begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB: begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND: begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:  begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_OR;  end
`ifdef MIPS_SLT_EN
                    FN_SLT: begin ctrl.reg_we = 1'b1; ctrl.alu_op = ALU_SLT; end
`endif
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrl.reg_we      = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_we      = 1'b1;
            end
            // Branches compare by subtracting and testing the zero flag.
            OP_BEQ: begin ctrl.alu_op = ALU_SUB; ctrl.branch_eq = 1'b1; end
            OP_BNE: begin ctrl.alu_op = ALU_SUB; ctrl.branch_ne = 1'b1; end
            OP_J:   ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    // Writes are blocked while rst is high so an edge seen during reset
    // commits nothing.
    assign reg_we_eff = ctrl.reg_we & ~rst;
    assign mem_we_eff = ctrl.mem_we & ~rst;
    assign wa         = ctrl.reg_dst_rd ? rd : rt;

    mips_single_cycle_regfile RegFile (
        .clk (clk),
        .we  (reg_we_eff),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (wa),
        .wd  (rfile_wd),
        .rd1 (rs_val),
        .rd2 (rt_val)
    );

    assign alu_b = ctrl.alu_src_imm ? imm_sext : rt_val;

    mips_single_cycle_alu alu (
        .a    (rs_val),
        .b    (alu_b),
        .op   (ctrl.alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    mips_single_cycle_mem #(.BYTES(DMEM_BYTES)) DatMem (
        .clk   (clk),
        .we    (mem_we_eff),
        .addr  (alu_y),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign rfile_wd = ctrl.mem_to_reg ? dmem_rdata : alu_y;

    // Next-pc selection.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign take_branch   = (ctrl.branch_eq & alu_zero) | (ctrl.branch_ne & ~alu_zero);

    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.jump) begin
            pc_d = jump_target;
        end else if (take_branch) begin
            pc_d = branch_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle: self-checking bench for mips_single_cycle.
// Loads a directed program plus a random R-type block through hierarchical
// paths, queues the expected write-back data and next pc for each executed
// instruction, and compares them cycle by cycle. Build with MIPS_SLT_EN to
// match a core built with SLT enabled.
module tb_mips_single_cycle;

    logic clk;
    logic rst;

    int err_cnt;
    int chk_cnt;
    int step_id;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_wd_q[$];
    logic        chk_wd_q[$];

    mips_single_cycle #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
        .clk (clk),
        .rst (rst)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] model_r(input int sel, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic put_instr(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            dut.InstrMem.mem_array[addr + k] = w[8*k +: 8];
        end
    endtask

    task automatic push_exp(input logic [31:0] wd, input logic chk, input logic [31:0] next_pc);
        exp_wd_q.push_back(wd);
        chk_wd_q.push_back(chk);
        exp_pc_q.push_back(next_pc);
    endtask

    function automatic logic [31:0] dm_word(input int addr);
        return {dut.DatMem.mem_array[addr + 3], dut.DatMem.mem_array[addr + 2],
                dut.DatMem.mem_array[addr + 1], dut.DatMem.mem_array[addr]};
    endfunction

    // Scoreboard: for each instruction, compare the write-back data while
    // the instruction is current, then the pc after its rising edge.
    task automatic run_checks(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ew;
            logic [31:0] ep;
            logic        c;
            if (exp_pc_q.size() == 0) begin
                check_val("scoreboard_empty", 32'd1, 32'd0);
                return;
            end
            ew = exp_wd_q.pop_front();
            c  = chk_wd_q.pop_front();
            ep = exp_pc_q.pop_front();
            #1;
            if (c) check_val($sformatf("wd_step%0d", step_id), dut.rfile_wd, ew);
            @(posedge clk);
            #1;
            check_val($sformatf("pc_step%0d", step_id), dut.pc, ep);
            step_id++;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rv [12:19];
        rst     = 1'b1;
        err_cnt = 0;
        chk_cnt = 0;
        step_id = 0;

        for (int i = 0; i < 1024; i++) begin
            dut.InstrMem.mem_array[i] = 8'hFF;   // opcode 63: unknown, acts as nop
            dut.DatMem.mem_array[i]   = 8'h00;
        end
        for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
        dut.RegFile.file_array[1] = 32'd5;
        dut.RegFile.file_array[2] = 32'd3;
        dut.RegFile.file_array[6] = 32'hDEAD_BEEF;
        dut.DatMem.mem_array[0] = 8'h78;
        dut.DatMem.mem_array[1] = 8'h56;
        dut.DatMem.mem_array[2] = 8'h34;
        dut.DatMem.mem_array[3] = 8'h12;
        dut.DatMem.mem_array[4] = 8'h9A;
        dut.DatMem.mem_array[5] = 8'hBC;

        // Directed program
        put_instr('h00, enc_r(1, 2, 3, 6'd32));          // add $3,$1,$2
        put_instr('h04, enc_r(1, 2, 4, 6'd34));          // sub $4,$1,$2
        put_instr('h08, enc_r(1, 2, 7, 6'd36));          // and $7,$1,$2
        put_instr('h0C, enc_r(1, 2, 8, 6'd37));          // or  $8,$1,$2
        put_instr('h10, enc_i(6'd4, 1, 1, 16'd2));       // beq $1,$1,+2
        put_instr('h1C, enc_i(6'd35, 0, 5, 16'd0));      // lw  $5,0($0)
        put_instr('h20, enc_i(6'd43, 0, 5, 16'd8));      // sw  $5,8($0)
        put_instr('h24, enc_r(1, 2, 0, 6'd32));          // add $0,$1,$2
        put_instr('h28, enc_r(0, 0, 9, 6'd37));          // or  $9,$0,$0
        put_instr('h2C, enc_r(2, 1, 6, 6'd42));          // slt $6,$2,$1
        put_instr('h30, enc_r(1, 2, 6, 6'd42));          // slt $6,$1,$2
        put_instr('h34, enc_r(6, 0, 10, 6'd32));         // add $10,$6,$0
        put_instr('h38, enc_i(6'd5, 1, 2, 16'd3));       // bne $1,$2,+3
        put_instr('h40, enc_i(6'd35, 0, 11, 16'd2));     // lw  $11,2($0) unaligned
        put_instr('h44, enc_i(6'd5, 1, 1, 16'd2));       // bne $1,$1,+2 (not taken)
        put_instr('h48, {6'd2, 26'h10});                 // j   0x10 -> 0x40

        push_exp(32'd8,          1'b1, 32'h04);
        push_exp(32'd2,          1'b1, 32'h08);
        push_exp(32'd1,          1'b1, 32'h0C);
        push_exp(32'd7,          1'b1, 32'h10);
        push_exp(32'd0,          1'b0, 32'h1C);
        push_exp(32'h1234_5678,  1'b1, 32'h20);
        push_exp(32'd0,          1'b0, 32'h24);
        push_exp(32'd8,          1'b1, 32'h28);
        push_exp(32'd0,          1'b1, 32'h2C);
`ifdef MIPS_SLT_EN
        push_exp(32'd1,          1'b1, 32'h30);
        push_exp(32'd0,          1'b1, 32'h34);
        push_exp(32'd0,          1'b1, 32'h38);
`else
        push_exp(32'd0,          1'b0, 32'h30);
        push_exp(32'd0,          1'b0, 32'h34);
        push_exp(32'hDEAD_BEEF,  1'b1, 32'h38);
`endif
        push_exp(32'd0,          1'b0, 32'h48);
        push_exp(32'd0,          1'b0, 32'h40);
        push_exp(32'hBC9A_1234,  1'b1, 32'h44);
        push_exp(32'd0,          1'b0, 32'h48);

        // Reset held 10 ns across the first rising edge.
        #10;
        check_val("rst_pc", dut.pc, 32'd0);
        rst = 1'b0;
        run_checks(16);

        check_val("sw_dm8",  dm_word(8), 32'h1234_5678);
        check_val("reg0",    dut.RegFile.file_array[5], 32'h1234_5678);

        // Mid-cycle reset clears pc at once.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async_pc", dut.pc, 32'd0);
        for (int k = 8; k < 12; k++) dut.DatMem.mem_array[k] = 8'h00;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_val("rerun_pc", dut.pc, 32'h20);

        // Reset while the sw is current: no memory or register write commits.
        @(negedge clk);
        #1;
        dut.RegFile.file_array[3] = 32'h0BAD_0BAD;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_pc_hold",    dut.pc, 32'd0);
        check_val("rst_no_sw",      dm_word(8), 32'd0);
        check_val("rst_no_regwr",   dut.RegFile.file_array[3], 32'h0BAD_0BAD);

        // Random R-type block at address 0.
        for (int r = 12; r < 20; r++) begin
            rv[r] = $urandom();
            dut.RegFile.file_array[r] = rv[r];
        end
        for (int i = 0; i < 12; i++) begin
            int sel, rs, rt, rd;
            logic [5:0] fn;
            sel = $urandom_range(0, 3);
            rs  = $urandom_range(12, 15);
            rt  = $urandom_range(16, 19);
            rd  = $urandom_range(20, 27);
            case (sel)
                0:       fn = 6'd32;
                1:       fn = 6'd34;
                2:       fn = 6'd36;
                default: fn = 6'd37;
            endcase
            put_instr(4 * i, enc_r(rs, rt, rd, fn));
            push_exp(model_r(sel, rv[rs], rv[rt]), 1'b1, 32'(4 * (i + 1)));
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_checks(12);

        check_val("queue_drained", 32'(exp_pc_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
